addr_field_pipe: RTL and testbench
==================================

ADDR_FIELD_PIPE -- requirements
Module: addr_field_pipe

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter LINE_BYTES, 64, cache line size in bytes; power of two, at least 4.
REQ-003 Parameter SETS, 16384, number of sets; power of two.
REQ-004 Parameter LEN_W, 7, width of the access-length field.
REQ-005 Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=ADDR_W-OFF_W-IDX_W; TAG_W<1 shall be an elaboration error.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 in_valid / in_ready  input / output  1 / 1  request handshake.
REQ-009 in_addr  input  ADDR_W  byte address of the access.
REQ-010 in_len  input  LEN_W  access length in bytes.
REQ-011 in_op  input  4  trace operation code, passed through unchanged.
REQ-012 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-013 out_addr, out_tag, out_index, out_offset  output  ADDR_W / TAG_W / IDX_W / OFF_W  per-beat address and its fields.
REQ-014 out_op  output  4  op code of the originating request.
REQ-015 out_split, out_last  output  1 / 1  request spans two lines; this is the final beat of the request.

Function
REQ-016 Field extraction: offset=addr[OFF_W-1:0]; index=addr[OFF_W+IDX_W-1:OFF_W]; tag=addr[ADDR_W-1:OFF_W+IDX_W].
REQ-017 Effective length: 0 becomes 1; any value above LINE_BYTES saturates to LINE_BYTES.
REQ-018 A request is a split when offset+effective length > LINE_BYTES; the comparison shall use OFF_W+2 bits so it cannot overflow.
REQ-019 An input is accepted on any edge where in_valid&&in_ready; beat 1 appears registered on the outputs one cycle later (latency 1).
REQ-020 FSM IDLE: in_ready=!out_valid||out_ready. An accepted split moves the FSM to SECOND.
REQ-021 FSM SECOND: in_ready=0. When beat 1 is consumed, the block loads beat 2 and returns to IDLE.
REQ-022 Beat 2 address = (line base of in_addr)+LINE_BYTES, modulo 2^ADDR_W; its offset is 0.
REQ-023 Split beats: out_split=1 on both beats; out_last=0 on beat 1 and 1 on beat 2. A non-split request has out_split=0 and out_last=1.
REQ-024 While out_valid&&!out_ready, all out_* signals shall hold stable.
REQ-025 Back-to-back: in IDLE, accepting a new request in the same cycle the current beat is consumed shall give full throughput with no bubble.
REQ-026 An input presented while in_ready=0 is ignored; the source must hold it until accepted.

Reset
REQ-027 rst_n low: out_valid=0, all out_* fields=0, FSM=IDLE, statistics counters=0.
REQ-028 Reset during SECOND discards the pending beat 2.
REQ-029 in_ready shall be 1 from the first clock edge after reset release.

Configuration
REQ-030 Macro ADDR_FIELD_PIPE_STATS_EN, when defined, adds outputs stat_req (32 bits, accepted requests) and stat_split (32 bits, accepted splits). Both counters wrap at 2^32.
REQ-031 Without ADDR_FIELD_PIPE_STATS_EN, those ports and counters do not exist and all other behaviour is identical.

Structure
REQ-032 Package addr_field_pkg shall hold the FSM state enum (IDLE, SECOND), an op-code enum (0 read, 1 write, 2 ifetch, 3 invalidate, 4 snoop, 8 clear, 9 print) and the width-derivation functions.
REQ-033 Sub-module addr_field_slice shall be the combinational field slicer (REQ-016). It is instantiated twice: once on the incoming address and once on the beat-2 address.

Verification (defaults: OFF_W=6, IDX_W=14, TAG_W=12)
REQ-034 in_addr=0x12345678, len=4, op=1 -> next cycle tag=0x123, index=0x1159, offset=0x38, op=1, split=0, last=1.
REQ-035 in_addr=0x0000003C, len=8 -> beat 1: addr=0x3C, offset=0x3C, last=0. Beat 2: addr=0x40, index=1, offset=0, last=1. in_ready=0 between the two beats.
REQ-036 in_addr=0xFFFFFFF8, len=16 -> beat 2: addr=0x00000000, tag=0, index=0 (wrap-around).
REQ-037 Hold out_ready=0 for 3 cycles on a valid beat -> out_* stable and in_ready=0. Then 10 back-to-back non-split requests with out_ready=1 -> 10 consecutive output beats with no bubble.
REQ-038 Assert rst_n low in SECOND -> out_valid=0 and beat 2 never appears. With STATS_EN, stat_req=0 and stat_split=0 after reset; after REQ-034 plus REQ-035, stat_req=2 and stat_split=1.

Source files
------------

// File: rtl/addr_field_pkg.sv
// Shared types and width helpers for the address field pipeline.
package addr_field_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_READ       = 4'd0,
        OP_WRITE      = 4'd1,
        OP_IFETCH     = 4'd2,
        OP_INVALIDATE = 4'd3,
        OP_SNOOP      = 4'd4,
        OP_CLEAR      = 4'd8,
        OP_PRINT      = 4'd9
    } op_t;

    function automatic int calc_off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int line_bytes, input int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

endpackage

// File: rtl/addr_field_slice.sv
// Combinational split of a byte address into tag, set index and line offset.
module addr_field_slice
    import addr_field_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 64,
    parameter  int SETS       = 16384,
    localparam int OFF_W      = calc_off_w(LINE_BYTES),
    localparam int IDX_W      = calc_idx_w(SETS),
    localparam int TAG_W      = calc_tag_w(ADDR_W, LINE_BYTES, SETS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [TAG_W-1:0]  tag,
    output logic [IDX_W-1:0]  index,
    output logic [OFF_W-1:0]  offset
);

    assign offset = addr[OFF_W-1:0];
    assign index  = addr[OFF_W+IDX_W-1:OFF_W];
    assign tag    = addr[ADDR_W-1:OFF_W+IDX_W];

endmodule

// File: rtl/addr_field_pipe.sv
// Registered address field pipeline; requests crossing a line boundary emit two beats.
// Optional statistics counters are enabled by defining ADDR_FIELD_PIPE_STATS_EN.
module addr_field_pipe
    import addr_field_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_BYTES = 64,
    parameter  int SETS       = 16384,
    parameter  int LEN_W      = 7,
    localparam int OFF_W      = calc_off_w(LINE_BYTES),
    localparam int IDX_W      = calc_idx_w(SETS),
    localparam int TAG_W      = calc_tag_w(ADDR_W, LINE_BYTES, SETS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [3:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [TAG_W-1:0]  out_tag,
    output logic [IDX_W-1:0]  out_index,
    output logic [OFF_W-1:0]  out_offset,
    output logic [3:0]        out_op,
    output logic              out_split,
`ifdef ADDR_FIELD_PIPE_STATS_EN
    output logic              out_last,
    output logic [31:0]       stat_req,
    output logic [31:0]       stat_split
`else
    output logic              out_last
`endif
);

    if (TAG_W < 1) begin : g_bad_tag
        $error("addr_field_pipe: tag width must be at least 1");
    end
    if (LINE_BYTES < 4 || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_bad_line
        $error("addr_field_pipe: LINE_BYTES must be a power of two >= 4");
    end
    if ((SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("addr_field_pipe: SETS must be a power of two");
    end

    state_t state, next_state;

    logic              accept;
    logic              load_second;
    logic [OFF_W+1:0]  eff_len;
    logic [OFF_W+1:0]  end_pos;
    logic              in_split;
    logic [ADDR_W-1:0] beat2_addr;
    logic [ADDR_W-1:0] pend_addr;

    logic [TAG_W-1:0]  in_tag,    pend_tag;
    logic [IDX_W-1:0]  in_index,  pend_index;
    logic [OFF_W-1:0]  in_offset, pend_offset;

    addr_field_slice #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES),
        .SETS       (SETS)
    ) u_slice_in (
        .addr   (in_addr),
        .tag    (in_tag),
        .index  (in_index),
        .offset (in_offset)
    );

    addr_field_slice #(
        .ADDR_W     (ADDR_W),
        .LINE_BYTES (LINE_BYTES),
        .SETS       (SETS)
    ) u_slice_pend (
        .addr   (pend_addr),
        .tag    (pend_tag),
        .index  (pend_index),
        .offset (pend_offset)
    );

    // Zero-length accesses still touch one byte; oversize ones are clamped to a line.
    always_comb begin
        if (in_len == '0) begin
            eff_len = (OFF_W+2)'(1);
        end else if (32'(in_len) > LINE_BYTES) begin
            eff_len = (OFF_W+2)'(LINE_BYTES);
        end else begin
            eff_len = (OFF_W+2)'(in_len);
        end
    end

    assign end_pos    = {2'b00, in_offset} + eff_len;
    assign in_split   = end_pos > (OFF_W+2)'(LINE_BYTES);
    assign beat2_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'(LINE_BYTES);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && in_split) next_state = SECOND;
            SECOND:  if (out_ready)          next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        load_second = 1'b0;
        case (state)
            IDLE:    in_ready    = !out_valid || out_ready;
            SECOND:  load_second = out_ready;
            default: in_ready    = 1'b0;
        endcase
    end

    // Output register holds its beat until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_tag    <= '0;
            out_index  <= '0;
            out_offset <= '0;
            out_op     <= '0;
            out_split  <= 1'b0;
            out_last   <= 1'b0;
            pend_addr  <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_addr   <= in_addr;
            out_tag    <= in_tag;
            out_index  <= in_index;
            out_offset <= in_offset;
            out_op     <= in_op;
            out_split  <= in_split;
            out_last   <= !in_split;
            pend_addr  <= beat2_addr;
        end else if (load_second) begin
            out_addr   <= pend_addr;
            out_tag    <= pend_tag;
            out_index  <= pend_index;
            out_offset <= pend_offset;
            out_last   <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ADDR_FIELD_PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req   <= '0;
            stat_split <= '0;
        end else if (accept) begin
            stat_req <= stat_req + 32'd1;
            if (in_split) begin
                stat_split <= stat_split + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addr_field_pipe.sv
// Self-checking bench for addr_field_pipe with default parameters.
// Define ADDR_FIELD_PIPE_STATS_EN to also check the statistics counters.
module tb_addr_field_pipe;

    localparam int LB   = 64;
    localparam int NSET = 16384;

    typedef struct {
        logic [31:0] addr;
        logic [11:0] tag;
        logic [13:0] idx;
        logic [5:0]  off;
        logic [3:0]  op;
        logic        split;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [6:0]  in_len;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [11:0] out_tag;
    logic [13:0] out_index;
    logic [5:0]  out_offset;
    logic [3:0]  out_op;
    logic        out_split;
    logic        out_last;
`ifdef ADDR_FIELD_PIPE_STATS_EN
    logic [31:0] stat_req;
    logic [31:0] stat_split;
`endif

    int checks   = 0;
    int failures = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    addr_field_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_len     (in_len),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_tag    (out_tag),
        .out_index  (out_index),
        .out_offset (out_offset),
        .out_op     (out_op),
        .out_split  (out_split),
`ifdef ADDR_FIELD_PIPE_STATS_EN
        .out_last   (out_last),
        .stat_req   (stat_req),
        .stat_split (stat_split)
`else
        .out_last   (out_last)
`endif
    );

    // Reference: derive the beat list of a request from arithmetic on the address.
    function automatic void model_push(input logic [31:0] addr, input int len, input logic [3:0] op);
        beat_t b;
        int unsigned off;
        int unsigned eff;
        logic [31:0] a2;
        off = addr % LB;
        eff = (len == 0) ? 1 : ((len > LB) ? LB : len);
        b.addr  = addr;
        b.off   = 6'(off);
        b.idx   = 14'((addr / LB) % NSET);
        b.tag   = 12'(addr / (LB * NSET));
        b.op    = op;
        b.split = (off + eff) > LB;
        b.last  = !b.split;
        exp_q.push_back(b);
        if (b.split) begin
            a2      = addr - off + LB;
            b.addr  = a2;
            b.off   = 6'(a2 % LB);
            b.idx   = 14'((a2 / LB) % NSET);
            b.tag   = 12'(a2 / (LB * NSET));
            b.last  = 1'b1;
            exp_q.push_back(b);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_len = '0; in_op = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_addr, out_tag, out_index, out_offset, out_op, out_split, out_last} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b addr=%h last=%b expected all zero", out_valid, out_addr, out_last);
        end
`ifdef ADDR_FIELD_PIPE_STATS_EN
        checks++;
        if (stat_req !== 32'd0 || stat_split !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_stats: got req=%0d split=%0d expected 0 0", stat_req, stat_split);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h12345678; in_len = 7'd4; in_op = 4'd1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_tag, out_index, out_offset, out_op, out_split, out_last} !==
            {1'b1, 12'h123, 14'h1159, 6'h38, 4'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL basic_fields: got v=%b tag=%h idx=%h off=%h op=%h split=%b last=%b expected v=1 tag=123 idx=1159 off=38 op=1 split=0 last=1",
                     out_valid, out_tag, out_index, out_offset, out_op, out_split, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_split();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h0000003C; in_len = 7'd8; in_op = 4'd2; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_addr, out_offset, out_split, out_last, in_ready} !==
            {1'b1, 32'h3C, 6'h3C, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL split_beat1: got v=%b addr=%h off=%h split=%b last=%b in_ready=%b expected v=1 addr=3c off=3c split=1 last=0 in_ready=0",
                     out_valid, out_addr, out_offset, out_split, out_last, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_addr, out_index, out_offset, out_op, out_split, out_last} !==
            {1'b1, 32'h40, 14'd1, 6'd0, 4'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL split_beat2: got v=%b addr=%h idx=%h off=%h op=%h split=%b last=%b expected v=1 addr=40 idx=1 off=0 op=2 split=1 last=1",
                     out_valid, out_addr, out_index, out_offset, out_op, out_split, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL split_drain: got v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_stats();
`ifdef ADDR_FIELD_PIPE_STATS_EN
        checks++;
        if (stat_req !== 32'd2 || stat_split !== 32'd1) begin
            failures++;
            $display("[TB] FAIL stats_count: got req=%0d split=%0d expected 2 1", stat_req, stat_split);
        end
`endif
    endtask

    task automatic test_wrap();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'hFFFFFFF8; in_len = 7'd16; in_op = 4'd0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_addr, out_tag, out_split, out_last} !== {1'b1, 32'hFFFFFFF8, 12'hFFF, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL wrap_beat1: got v=%b addr=%h tag=%h split=%b last=%b expected v=1 addr=fffffff8 tag=fff split=1 last=0",
                     out_valid, out_addr, out_tag, out_split, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_addr, out_tag, out_index, out_offset, out_last} !== {1'b1, 32'h0, 12'h0, 14'h0, 6'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL wrap_beat2: got v=%b addr=%h tag=%h idx=%h off=%h last=%b expected v=1 addr=0 tag=0 idx=0 off=0 last=1",
                     out_valid, out_addr, out_tag, out_index, out_offset, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [10];
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'hABCD1200; in_len = 7'd4; in_op = 4'd4; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_addr = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_addr, out_op, out_last, in_ready} !== {1'b1, 32'hABCD1200, 4'd4, 1'b1, 1'b0}) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b addr=%h op=%h last=%b in_ready=%b expected v=1 addr=abcd1200 op=4 last=1 in_ready=0",
                         i, out_valid, out_addr, out_op, out_last, in_ready);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            addrs[k] = {$urandom_range(0, 32'h03FF_FFFF), 6'd0};
            in_valid = 1'b1; in_addr = addrs[k]; in_len = 7'(1 + (k % 8)); in_op = 4'(k); out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_addr !== ((k == 0) ? 32'hABCD1200 : addrs[(k == 0) ? 0 : k - 1])) begin
                failures++;
                $display("[TB] FAIL b2b_%0d: got in_ready=%b v=%b addr=%h expected in_ready=1 v=1 addr of previous request",
                         k, in_ready, out_valid, out_addr);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== addrs[9] || out_op !== 4'd9) begin
            failures++;
            $display("[TB] FAIL b2b_tail: got v=%b addr=%h op=%h expected v=1 addr=%h op=9", out_valid, out_addr, out_op, addrs[9]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] cur_addr = '0;
        int          cur_len  = 0;
        logic [3:0]  cur_op   = '0;
        logic        cur_valid = 1'b0;
        logic        taken    = 1'b1;
        logic        exp_ready;
        beat_t       e;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (!cur_valid || taken) begin
                cur_valid = (cyc < 580) && ($urandom_range(0, 3) != 0);
                cur_addr  = $urandom;
                if ($urandom_range(0, 1) == 1) cur_addr[5:0] = 6'(64 - $urandom_range(1, 12));
                cur_len   = $urandom_range(0, 127);
                cur_op    = 4'($urandom_range(0, 15));
            end
            in_valid  = cur_valid;
            in_addr   = cur_addr;
            in_len    = 7'(cur_len);
            in_op     = cur_op;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            checks++;
            if (in_ready !== exp_ready || out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("[TB] FAIL rand_hs_%0d: got in_ready=%b v=%b expected in_ready=%b v=%b",
                         cyc, in_ready, out_valid, exp_ready, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                checks++;
                if ({out_addr, out_tag, out_index, out_offset, out_op, out_split, out_last} !==
                    {e.addr, e.tag, e.idx, e.off, e.op, e.split, e.last}) begin
                    failures++;
                    $display("[TB] FAIL rand_beat_%0d: got addr=%h tag=%h idx=%h off=%h op=%h split=%b last=%b expected addr=%h tag=%h idx=%h off=%h op=%h split=%b last=%b",
                             cyc, out_addr, out_tag, out_index, out_offset, out_op, out_split, out_last,
                             e.addr, e.tag, e.idx, e.off, e.op, e.split, e.last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
            taken = cur_valid && exp_ready;
            if (taken) model_push(cur_addr, cur_len, cur_op);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset_second();
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h000007F0; in_len = 7'd32; in_op = 4'd3; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst2_pre: got v=%b last=%b in_ready=%b expected 1 0 0", out_valid, out_last, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rst2_async: got v=%b addr=%h expected 0 0", out_valid, out_addr);
        end
`ifdef ADDR_FIELD_PIPE_STATS_EN
        checks++;
        if (stat_req !== 32'd0 || stat_split !== 32'd0) begin
            failures++;
            $display("[TB] FAIL rst2_stats: got req=%0d split=%0d expected 0 0", stat_req, stat_split);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rst2_no_beat2_%0d: got v=%b in_ready=%b expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split();
        test_stats();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_second();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
